// File: rtl/pipe_hazard_ctrl.sv
// Purpose : stall/flush controller for the 5-stage pipeline (load-use, MDU, dmem wait, branch squash).
// Latency : handshake outputs are combinational from state+inputs; state/counters update on clk.
// Backpr. : stages are held via *_ready_go=0; the MEM stall backpressures every state.
//
// Ports:
//   clk, rst                    rising-edge clock, async active-high reset
//   id_* / ex_* / mem_*         per-stage occupancy and hazard information
//   stall_clr                   synchronous clear of stall_cnt
//   *_ready_go, *_clear         per-stage-register handshake controls
//   pc_redirect, mdu_start      branch-target select, one-cycle MDU issue pulse
//   state, stall_cnt            FSM state (0 RUN, 1 MDU_WAIT, 2 FLUSH), saturating stall count
module pipe_hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 8,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic              ex_wen,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_mdu,
  input  logic              ex_branch_taken,
  input  logic              mem_valid,
  input  logic              mem_is_mem,
  input  logic              mem_ready,
  input  logic              stall_clr,
  output logic              if_id_ready_go,
  output logic              id_ex_ready_go,
  output logic              ex_mem_ready_go,
  output logic              mem_wb_ready_go,
  output logic              if_id_clear,
  output logic              id_ex_clear,
  output logic              pc_redirect,
  output logic              mdu_start,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MDU_WAIT = 2'd1;
  localparam logic [1:0] FLUSH    = 2'd2;

  logic [7:0] mdu_cnt;
  logic [1:0] state_nxt;
  logic       mem_stall;
  logic       load_use;
  logic       mdu_issue;
  logic       br_fire;
  logic       any_stall;

  assign mem_stall = mem_valid & mem_is_mem & ~mem_ready;

  // ex_rd==0 is the hardwired zero register, so it never creates a dependency.
  assign load_use = id_valid & ex_valid & ex_is_load & ex_wen & (ex_rd != '0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  // MDU issue beats a branch on the same instruction; a branch waits out a MEM stall
  // so the redirect and squash happen on the cycle the pipe can actually move.
  assign mdu_issue = (state == RUN) & ex_valid & ex_is_mdu;
  assign br_fire   = (state == RUN) & ex_valid & ex_branch_taken & ~ex_is_mdu & ~mem_stall;

  assign ex_mem_ready_go = ~mem_stall;
  assign mem_wb_ready_go = 1'b1;

  always_comb begin
    if_id_ready_go = 1'b1;
    id_ex_ready_go = 1'b1;
    if_id_clear    = 1'b0;
    id_ex_clear    = 1'b0;
    pc_redirect    = 1'b0;
    mdu_start      = 1'b0;
    state_nxt      = state;
    case (state)
      RUN: begin
        if (mdu_issue) begin
          mdu_start      = 1'b1;
          id_ex_ready_go = 1'b0;
          if_id_ready_go = ~load_use;
          state_nxt      = MDU_WAIT;
        end else if (br_fire) begin
          // Redirect squashes ID, so a load-use stall there is moot.
          pc_redirect = 1'b1;
          if_id_clear = 1'b1;
          id_ex_clear = 1'b1;
          state_nxt   = FLUSH;
        end else begin
          if_id_ready_go = ~load_use;
        end
      end
      MDU_WAIT: begin
        if_id_ready_go = ~load_use;
        id_ex_ready_go = (mdu_cnt <= 8'd1);
        if ((mdu_cnt <= 8'd1) && !mem_stall) state_nxt = RUN;
      end
      FLUSH: begin
        // ID/EX hold zeroed payloads: their hazard flags are meaningless here.
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign any_stall = ~if_id_ready_go | ~id_ex_ready_go | ~ex_mem_ready_go;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      mdu_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (mdu_issue)
        mdu_cnt <= 8'(MDU_LAT);
      else if ((state == MDU_WAIT) && (mdu_cnt > 8'd1))
        mdu_cnt <= mdu_cnt - 8'd1;
      if (stall_clr)
        stall_cnt <= '0;
      else if (any_stall && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage handshake pipeline (IF_ID, ID_EX, EX_MEM, MEM_WB register stages).
- Drives each stage register's pipe_ready_go and clear inputs.
- Detects load-use hazards, sequences multi-cycle MDU ops, holds for data-memory wait, and squashes wrong-path instructions on a taken branch.
- Keeps a saturating stall-cycle performance counter.

Parameters:
REG_AW, 5, register address width
MDU_LAT, 8, MDU wait cycles after issue (legal range 1..255)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  ID stage holds a valid instruction
id_rs1  in  REG_AW  ID source register 1
id_rs2  in  REG_AW  ID source register 2
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_valid  in  1  EX stage holds a valid instruction
ex_is_load  in  1  EX instruction is a load
ex_wen  in  1  EX instruction writes rd
ex_rd  in  REG_AW  EX destination register
ex_is_mdu  in  1  EX instruction is a multiply/divide
ex_branch_taken  in  1  EX resolved a taken branch/jump
mem_valid  in  1  MEM stage holds a valid instruction
mem_is_mem  in  1  MEM instruction accesses data memory
mem_ready  in  1  data memory response available
stall_clr  in  1  synchronous clear of stall_cnt
if_id_ready_go  out  1  ID stage work done
id_ex_ready_go  out  1  EX stage work done
ex_mem_ready_go  out  1  MEM stage work done
mem_wb_ready_go  out  1  WB stage work done (constant 1)
if_id_clear  out  1  zero IF_ID payload
id_ex_clear  out  1  zero ID_EX payload
pc_redirect  out  1  select branch target as next PC
mdu_start  out  1  one-cycle MDU issue pulse
state  out  2  FSM state: 0 RUN, 1 MDU_WAIT, 2 FLUSH
stall_cnt  out  CNT_W  saturating stall-cycle count

Behaviour:
- Reset: rst asynchronously forces RUN, mdu_cnt=0, stall_cnt=0. This applies mid-MDU or mid-FLUSH; any in-flight MDU op is abandoned.
- All handshake outputs are combinational from the state and inputs.
- With all inputs 0 in RUN: all ready_go=1; all clears, pc_redirect and mdu_start=0; state=0.
- mem_stall = mem_valid & mem_is_mem & !mem_ready.
  - ex_mem_ready_go = !mem_stall, in every state.
- load_use = id_valid & ex_valid & ex_is_load & ex_wen & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - if_id_ready_go = !load_use in RUN; forced 1 in FLUSH.
  - Stall is one cycle: the load advances and load_use drops.
- RUN, ex_valid & ex_is_mdu:
  - mdu_start=1 and id_ex_ready_go=0.
  - Next state MDU_WAIT, mdu_cnt<=MDU_LAT.
  - If mem_stall is also high, mdu_start is still issued; the MDU result is held in EX.
- MDU_WAIT:
  - mdu_cnt decrements each cycle, floored at 1.
  - id_ex_ready_go=0 while mdu_cnt>1. At mdu_cnt==1, id_ex_ready_go=1.
  - Return to RUN on the cycle where id_ex_ready_go=1 and ex_mem_ready_go=1; otherwise hold at mdu_cnt==1.
  - EX occupancy is exactly MDU_LAT+1 cycles when there is no memory stall.
  - mdu_start=0 throughout MDU_WAIT.
- Taken branch in RUN: when ex_valid & ex_branch_taken & !ex_is_mdu & !mem_stall:
  - pc_redirect=1, if_id_clear=1, id_ex_clear=1 for exactly that cycle.
  - Next state FLUSH.
  - A branch under mem_stall is deferred until mem_ready.
- ex_is_mdu & ex_branch_taken together: MDU wins and the branch is ignored.
- FLUSH lasts one cycle:
  - pc_redirect, clears and mdu_start are 0.
  - load_use and ex_is_mdu are ignored, because EX/ID hold zeroed payloads.
  - id_ex_ready_go=1. Then return to RUN.
- Priority in RUN: MDU issue > branch redirect > load-use. When a redirect fires, if_id_ready_go=1 (no load_use stall) that cycle.
- stall_cnt increments by 1 on each cycle where any of if_id_ready_go, id_ex_ready_go, ex_mem_ready_go is 0.
  - Saturates at all-ones.
  - stall_clr wins over increment (result 0).
- mem_wb_ready_go is tied to 1.

Test Plan:
- Reset then idle 5 cycles: state=0, all ready_go=1, clears=0, stall_cnt=0. Assert rst mid-cycle: outputs return immediately.
- Load-use: ex_is_load=1, ex_wen=1, ex_rd=5, id_rs2=5, id_use_rs2=1, both valid -> if_id_ready_go=0 for 1 cycle, stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- MDU with MDU_LAT=8, ex_is_mdu=1 held:
  - mdu_start pulses once.
  - id_ex_ready_go=0 for 8 cycles, then 1 on the 9th cycle; back to RUN.
  - stall_cnt=8.
- MDU completion with mem_stall held 3 extra cycles -> state stays 1 at mdu_cnt=1 until mem_ready; single mdu_start.
- Branch: ex_branch_taken=1 -> pc_redirect, if_id_clear, id_ex_clear high 1 cycle, state=2 for 1 cycle. Load_use present during FLUSH is ignored. Branch with mem_stall -> deferred to the mem_ready cycle.
- Saturation: CNT_W=4, 20 stall cycles -> stall_cnt=15. stall_clr with concurrent stall -> 0.
